pci_bus_arbiter: RTL and testbench
==================================

PCI_BUS_ARBITER -- requirements
Module: pci_bus_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4, meaning number of requesting initiators, legal range 2..8.
REQ-002 Parameter PARK_MASTER, default 0, meaning index granted when no request is pending.
REQ-003 Parameter GNT_TIMEOUT, default 16, meaning idle-bus cycles a granted master has to assert FRAME, legal range 2..255.
REQ-004 CLK  input  1  clock; all state changes on rising edge.
REQ-005 RST  input  1  reset, asynchronous and active-high.
REQ-006 REQ  input  NUM_MASTERS  per-master bus request, active-low.
REQ-007 FRAME  input  1  shared bus FRAME, active-low, monitored only.
REQ-008 IRDY  input  1  shared bus IRDY, active-low, monitored only.
REQ-009 GNT  output  NUM_MASTERS  per-master grant, active-low, registered, at most one bit low.
REQ-010 OWNER  output  3  index of master holding or last granted the bus.
REQ-011 BUS_BUSY  output  1  high while the arbiter is in XFER or TURN.
REQ-012 TIMEOUT  output  1  one-cycle high pulse when a grant is revoked by timeout.

Function
REQ-013 States SHALL be IDLE, PARK, GRANT, XFER and TURN; GNT is all-high in IDLE and TURN.
REQ-014 IDLE: any REQ low -> GRANT to the round-robin winner; else -> PARK with OWNER=PARK_MASTER.
REQ-015 Round-robin: search starts at LAST+1 modulo NUM_MASTERS, where LAST is the most recent master to start a transaction; LAST resets to NUM_MASTERS-1.
REQ-016 PARK: GNT[PARK_MASTER] low; FRAME sampled low -> XFER; REQ[PARK_MASTER] low only -> GRANT with no gap; any other REQ low -> IDLE (one-cycle all-high gap).
REQ-017 GRANT: GNT[OWNER] low; FRAME sampled low -> XFER; else REQ[OWNER] high (withdrawn) -> IDLE.
REQ-018 Entry to XFER SHALL set LAST=OWNER.
REQ-019 XFER: GNT[OWNER] held low; FRAME sampled high -> TURN with GNT all-high in the following cycle.
REQ-020 TURN: stay while IRDY low; IRDY sampled high -> IDLE, giving at least one full all-high turnaround cycle.
REQ-021 A grant SHALL never move directly from one master to another; every owner change passes through IDLE or TURN.
REQ-022 REQ changes during XFER or TURN SHALL NOT affect GNT until IDLE is re-entered.
REQ-023 FRAME low while in IDLE or TURN (protocol error) SHALL move to XFER with OWNER unchanged.

Reset
REQ-024 While RST high: state=IDLE, GNT all-high, OWNER=PARK_MASTER, LAST=NUM_MASTERS-1, BUS_BUSY=0, TIMEOUT=0, timeout counter=0.
REQ-025 RST asserted mid-transaction SHALL deassert GNT immediately (asynchronously), regardless of FRAME/IRDY.
REQ-026 First rising edge after RST falls SHALL evaluate REQ per REQ-014.

Configuration
REQ-027 Macro PCI_ARB_TIMEOUT_EN SHALL compile in the grant timeout.
REQ-028 With PCI_ARB_TIMEOUT_EN: in GRANT, a counter counts cycles with FRAME and IRDY both high; reaching GNT_TIMEOUT -> IDLE, TIMEOUT pulses 1 cycle, LAST=OWNER so the master loses priority.
REQ-029 Without PCI_ARB_TIMEOUT_EN: no counter, GRANT persists until FRAME low or REQ withdrawn, TIMEOUT tied 0.
REQ-030 The counter SHALL clear on every entry to GRANT.

Verification
REQ-031 Reset, REQ=4'b1111 -> after 1 cycle GNT=4'b1110 (park on 0), OWNER=0, BUS_BUSY=0.
REQ-032 Parked, REQ=4'b1011 -> GNT 4'b1111 for 1 cycle then 4'b1011; FRAME low 3 cycles then high, IRDY high 1 cycle later -> GNT all-high at least 1 cycle, BUS_BUSY high XFER..TURN.
REQ-033 REQ=4'b0000 held, each master runs a 2-cycle FRAME transaction -> grant order 0,1,2,3,0, OWNER following.
REQ-034 Master 2 granted during another's XFER, REQ[2] raised before FRAME -> GNT all-high next cycle, re-arbitration among remaining requests.
REQ-035 With PCI_ARB_TIMEOUT_EN, REQ=4'b1101, FRAME never asserted -> after 16 idle cycles TIMEOUT=1 one cycle, GNT all-high; without macro GNT stays 4'b1101 indefinitely.
REQ-036 RST pulsed high during XFER of master 1 -> GNT=4'b1111 within the same cycle, OWNER=0 after release.

Source files
------------

// File: rtl/pci_bus_arbiter.sv
// Round-robin PCI bus arbiter with bus parking and turnaround enforcement.
// Optional grant timeout is compiled in with `define PCI_ARB_TIMEOUT_EN.
module pci_bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int PARK_MASTER = 0,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_MASTERS-1:0] REQ,
    input  logic                   FRAME,
    input  logic                   IRDY,
    output logic [NUM_MASTERS-1:0] GNT,
    output logic [2:0]             OWNER,
    output logic                   BUS_BUSY,
    output logic                   TIMEOUT
);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
        $error("NUM_MASTERS must be in 2..8");
    end
    if (PARK_MASTER < 0 || PARK_MASTER >= NUM_MASTERS) begin : g_bad_park_master
        $error("PARK_MASTER must index an existing master");
    end
    if (GNT_TIMEOUT < 2 || GNT_TIMEOUT > 255) begin : g_bad_gnt_timeout
        $error("GNT_TIMEOUT must be in 2..255");
    end

    localparam logic [2:0] PARK_IDX = 3'(PARK_MASTER);
    localparam logic [2:0] LAST_RST = 3'(NUM_MASTERS - 1);

    typedef enum logic [2:0] {IDLE, PARK, GRANT, XFER, TURN} state_t;

    state_t                   state_reg, state_next;
    logic [2:0]               owner_reg, owner_next;
    logic [2:0]               last_reg, last_next;
    logic [NUM_MASTERS-1:0]   gnt_reg, gnt_next;
    logic [NUM_MASTERS-1:0]   req_act, owner_hit, park_onehot, rot;
    logic                     owner_req, park_req, other_req, any_req, drive_next;
    logic [2:0]               start, winner;
    int                       w;

    assign req_act = ~REQ;

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_decode
        assign owner_hit[gi]   = (owner_reg == 3'(gi));
        assign park_onehot[gi] = (gi == PARK_MASTER);
        assign gnt_next[gi]    = ~(drive_next && (owner_next == 3'(gi)));
    end

    assign owner_req = |(req_act & owner_hit);
    assign park_req  = |(req_act & park_onehot);
    assign other_req = |(req_act & ~park_onehot);
    assign any_req   = |req_act;

    // Rotate requests so bit 0 is the master right after LAST, then take the lowest set bit.
    always_comb begin
        start  = (last_reg >= LAST_RST) ? 3'd0 : last_reg + 3'd1;
        rot    = NUM_MASTERS'({req_act, req_act} >> start);
        winner = 3'd0;
        w      = 0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                w = int'(start) + k;
                if (w >= NUM_MASTERS) w = w - NUM_MASTERS;
                winner = 3'(w);
            end
        end
    end

`ifdef PCI_ARB_TIMEOUT_EN
    logic [7:0] cnt_reg, cnt_next;
    logic       timeout_reg, timeout_next;
`endif

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
`ifdef PCI_ARB_TIMEOUT_EN
        cnt_next     = cnt_reg;
        timeout_next = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (!FRAME) begin
                    state_next = XFER;
                end else if (any_req) begin
                    state_next = GRANT;
                    owner_next = winner;
                end else begin
                    state_next = PARK;
                    owner_next = PARK_IDX;
                end
            end
            PARK: begin
                if (!FRAME)         state_next = XFER;
                else if (other_req) state_next = IDLE;
                else if (park_req)  state_next = GRANT;
            end
            GRANT: begin
                if (!FRAME) begin
                    state_next = XFER;
                end else if (!owner_req) begin
                    state_next = IDLE;
`ifdef PCI_ARB_TIMEOUT_EN
                end else if (IRDY) begin
                    if (cnt_reg == 8'(GNT_TIMEOUT - 1)) begin
                        state_next   = IDLE;
                        timeout_next = 1'b1;
                        last_next    = owner_reg;
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                    end
`endif
                end
            end
            XFER: begin
                if (FRAME) state_next = TURN;
            end
            TURN: begin
                if (!FRAME)    state_next = XFER;
                else if (IRDY) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (state_next == XFER && state_reg != XFER) last_next = owner_next;
`ifdef PCI_ARB_TIMEOUT_EN
        if (state_next == GRANT && state_reg != GRANT) cnt_next = 8'd0;
`endif
    end

    assign drive_next = (state_next == PARK) || (state_next == GRANT) || (state_next == XFER);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
            owner_reg <= PARK_IDX;
            last_reg  <= LAST_RST;
            gnt_reg   <= '1;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
            gnt_reg   <= gnt_next;
        end
    end

`ifdef PCI_ARB_TIMEOUT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_reg     <= 8'd0;
            timeout_reg <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end
    assign TIMEOUT = timeout_reg;
`else
    assign TIMEOUT = 1'b0;
`endif

    assign GNT      = gnt_reg;
    assign OWNER    = owner_reg;
    assign BUS_BUSY = (state_reg == XFER) || (state_reg == TURN);

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter (4 masters, park on 0, timeout 16).
module tb_pci_bus_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] REQ;
    logic       FRAME;
    logic       IRDY;
    logic [3:0] GNT;
    logic [2:0] OWNER;
    logic       BUS_BUSY;
    logic       TIMEOUT;

    int total = 0;
    int bad   = 0;

    pci_bus_arbiter #(.NUM_MASTERS(4), .PARK_MASTER(0), .GNT_TIMEOUT(16)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .FRAME(FRAME), .IRDY(IRDY),
        .GNT(GNT), .OWNER(OWNER), .BUS_BUSY(BUS_BUSY), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Starts in GRANT: checks the grant, runs a 2-cycle FRAME transfer, ends in IDLE.
    task automatic txn(input logic [2:0] exp_owner, input logic [3:0] exp_gnt);
        check("txn_grant", {4'h0, GNT}, {4'h0, exp_gnt});
        check("txn_owner", {5'h0, OWNER}, {5'h0, exp_owner});
        FRAME = 1'b0; IRDY = 1'b0;
        step();
        check("txn_xfer_busy", {7'h0, BUS_BUSY}, 8'h01);
        check("txn_xfer_gnt", {4'h0, GNT}, {4'h0, exp_gnt});
        step();
        check("txn_xfer2_gnt", {4'h0, GNT}, {4'h0, exp_gnt});
        FRAME = 1'b1;
        step();
        check("txn_turn_gnt", {4'h0, GNT}, 8'h0f);
        check("txn_turn_busy", {7'h0, BUS_BUSY}, 8'h01);
        IRDY = 1'b1;
        step();
        check("txn_idle_gnt", {4'h0, GNT}, 8'h0f);
        check("txn_idle_busy", {7'h0, BUS_BUSY}, 8'h00);
        $display("txn owner=%0d gnt=%b", exp_owner, exp_gnt);
    endtask

    initial begin
        RST = 1'b1; REQ = 4'b1111; FRAME = 1'b1; IRDY = 1'b1;
        step(); step();
        check("rst_gnt", {4'h0, GNT}, 8'h0f);
        check("rst_owner", {5'h0, OWNER}, 8'h00);
        check("rst_busy", {7'h0, BUS_BUSY}, 8'h00);
        check("rst_timeout", {7'h0, TIMEOUT}, 8'h00);

        // Park after reset
        RST = 1'b0;
        step();
        check("park_gnt", {4'h0, GNT}, 8'h0e);
        check("park_owner", {5'h0, OWNER}, 8'h00);
        check("park_busy", {7'h0, BUS_BUSY}, 8'h00);

        // Master 2 from park: one-cycle gap then grant, 3-cycle FRAME
        REQ = 4'b1011;
        step();
        check("m2_gap", {4'h0, GNT}, 8'h0f);
        step();
        check("m2_gnt", {4'h0, GNT}, 8'h0b);
        check("m2_owner", {5'h0, OWNER}, 8'h02);
        FRAME = 1'b0; IRDY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("m2_xfer_gnt", {4'h0, GNT}, 8'h0b);
            check("m2_xfer_busy", {7'h0, BUS_BUSY}, 8'h01);
        end
        FRAME = 1'b1;
        step();
        check("m2_turn_gnt", {4'h0, GNT}, 8'h0f);
        check("m2_turn_busy", {7'h0, BUS_BUSY}, 8'h01);
        IRDY = 1'b1; REQ = 4'b1111;
        step();
        check("m2_idle_gnt", {4'h0, GNT}, 8'h0f);
        check("m2_idle_busy", {7'h0, BUS_BUSY}, 8'h00);
        step();
        check("m2_repark", {4'h0, GNT}, 8'h0e);

        // Round robin from a fresh reset with all masters requesting
        RST = 1'b1;
        step();
        RST = 1'b0; REQ = 4'b0000;
        step(); txn(3'd0, 4'b1110);
        step(); txn(3'd1, 4'b1101);
        step(); txn(3'd2, 4'b1011);
        step(); txn(3'd3, 4'b0111);
        step();
        check("rr_wrap_gnt", {4'h0, GNT}, 8'h0e);
        check("rr_wrap_owner", {5'h0, OWNER}, 8'h00);

        // REQ changes during XFER are ignored; master 2 then withdraws
        FRAME = 1'b0; IRDY = 1'b0;
        step();
        REQ = 4'b1011;
        step();
        check("xfer_req_ignored", {4'h0, GNT}, 8'h0e);
        FRAME = 1'b1;
        step();
        check("w_turn", {4'h0, GNT}, 8'h0f);
        IRDY = 1'b1;
        step();
        check("w_idle", {4'h0, GNT}, 8'h0f);
        step();
        check("w_m2_gnt", {4'h0, GNT}, 8'h0b);
        check("w_m2_owner", {5'h0, OWNER}, 8'h02);
        REQ = 4'b0110;
        step();
        check("w_withdraw_gap", {4'h0, GNT}, 8'h0f);
        step();
        check("w_rearb_gnt", {4'h0, GNT}, 8'h07);
        check("w_rearb_owner", {5'h0, OWNER}, 8'h03);
        REQ = 4'b1111;
        step();
        check("w_m3_drop", {4'h0, GNT}, 8'h0f);
        step();
        check("w_repark", {4'h0, GNT}, 8'h0e);

        // Park master alone requesting: grant without gap
        REQ = 4'b1110;
        step();
        check("park_to_grant", {4'h0, GNT}, 8'h0e);
        REQ = 4'b1111;
        step();
        check("park_grant_drop", {4'h0, GNT}, 8'h0f);
        step();
        check("park_again", {4'h0, GNT}, 8'h0e);

        // FRAME low while IDLE: protocol error goes to XFER with owner unchanged
        REQ = 4'b1101;
        step();
        check("perr_idle", {4'h0, GNT}, 8'h0f);
        FRAME = 1'b0;
        step();
        check("perr_xfer_gnt", {4'h0, GNT}, 8'h0e);
        check("perr_xfer_owner", {5'h0, OWNER}, 8'h00);
        check("perr_xfer_busy", {7'h0, BUS_BUSY}, 8'h01);
        FRAME = 1'b1;
        step();
        check("perr_turn", {4'h0, GNT}, 8'h0f);
        step();
        check("perr_idle_busy", {7'h0, BUS_BUSY}, 8'h00);
        step();
        check("m1_gnt", {4'h0, GNT}, 8'h0d);
        check("m1_owner", {5'h0, OWNER}, 8'h01);

        // Granted master never drives FRAME
`ifdef PCI_ARB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            step();
            check("to_wait_gnt", {4'h0, GNT}, 8'h0d);
            check("to_wait_pulse", {7'h0, TIMEOUT}, 8'h00);
        end
        step();
        check("to_fire_gnt", {4'h0, GNT}, 8'h0f);
        check("to_fire_pulse", {7'h0, TIMEOUT}, 8'h01);
        step();
        check("to_pulse_end", {7'h0, TIMEOUT}, 8'h00);
        check("to_regrant", {4'h0, GNT}, 8'h0d);
`else
        for (int i = 0; i < 20; i++) begin
            step();
            check("nto_hold_gnt", {4'h0, GNT}, 8'h0d);
            check("nto_pulse", {7'h0, TIMEOUT}, 8'h00);
        end
`endif
        $display("timeout phase done gnt=%b", GNT);

        // Asynchronous reset during master 1 transfer
        FRAME = 1'b0; IRDY = 1'b0;
        step();
        check("ar_xfer_gnt", {4'h0, GNT}, 8'h0d);
        #2 RST = 1'b1;
        #1;
        check("ar_gnt_now", {4'h0, GNT}, 8'h0f);
        check("ar_busy_now", {7'h0, BUS_BUSY}, 8'h00);
        step();
        RST = 1'b0; REQ = 4'b1111; FRAME = 1'b1; IRDY = 1'b1;
        check("ar_owner", {5'h0, OWNER}, 8'h00);
        step();
        check("ar_park", {4'h0, GNT}, 8'h0e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
